// File: rtl/blink_tick_gen.sv
// ============================================================================
// Module      : blink_tick_gen
// Description : Rate-selectable tick prescaler. A debounced button cycles the
//               rate through 0..3, and each rate step doubles the tick rate.
//               Optional macro BLINK_TICK_SYNC_EN puts a two-flop synchronizer
//               in front of the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_tick_gen #(
    parameter int BASE_DIV   = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       run_en,
    output logic       tick,
    output logic [1:0] rate,
    output logic       btn_level
);

    localparam int CW = $clog2(8 * BASE_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [CW:0]   c_BASE     = (CW + 1)'(BASE_DIV);
    localparam logic [CW:0]   c_ONE      = (CW + 1)'(1);
    localparam logic [DW-1:0] c_DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {
        S_REL = 1'b0,
        S_PRS = 1'b1
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dcnt;
    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic [1:0]    r_rate;
    logic          r_btn_level;

    logic          w_btn_s;
    logic          w_differ;
    logic          w_switch;
    logic          w_press;
    logic [CW:0]   w_period;
    logic [CW:0]   w_last;
    logic          w_wrap;

`ifdef BLINK_TICK_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn};
        end
    end

    assign w_btn_s = r_sync[1];
`else
    assign w_btn_s = btn;
`endif

    assign w_differ = (w_btn_s != r_btn_level);
    assign w_switch = w_differ && (r_dcnt == c_DEB_LAST);
    assign w_press  = w_switch && (r_state == S_REL);

    // Debounce FSM; rate advances only on an accepted release-to-press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_REL;
            r_dcnt      <= '0;
            r_rate      <= 2'd0;
            r_btn_level <= 1'b0;
        end else begin
            if (!w_differ) begin
                r_dcnt <= '0;
            end else if (w_switch) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
            case (r_state)
                S_REL: begin
                    if (w_switch) begin
                        r_state     <= S_PRS;
                        r_btn_level <= 1'b1;
                        r_rate      <= r_rate + 2'd1;
                    end
                end
                S_PRS: begin
                    if (w_switch) begin
                        r_state     <= S_REL;
                        r_btn_level <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_REL;
                    r_btn_level <= 1'b0;
                end
            endcase
        end
    end

    assign w_period = c_BASE << (2'd3 - r_rate);
    assign w_last   = w_period - c_ONE;
    assign w_wrap   = ({1'b0, r_cnt} == w_last);

    // A rate change restarts the period, overriding any coincident wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_press) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (run_en) begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick      = r_tick;
    assign rate      = r_rate;
    assign btn_level = r_btn_level;

endmodule

`default_nettype wire

// File: tb/tb_blink_tick_gen.sv
// ============================================================================
// Module      : tb_blink_tick_gen
// Description : Directed bench for blink_tick_gen with a tick scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blink_tick_gen;

    localparam int BASE_DIV   = 4;
    localparam int DEB_CYCLES = 3;
`ifdef BLINK_TICK_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk;
    logic       reset;
    logic       btn;
    logic       run_en;
    logic       tick;
    logic [1:0] rate;
    logic       btn_level;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n;
    int nt;
    int cur_p;
    int q[$];
    bit m_exp;

    blink_tick_gen #(
        .BASE_DIV   (BASE_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .run_en    (run_en),
        .tick      (tick),
        .rate      (rate),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Tick scoreboard: expected tick edges are queued ahead by the stimulus.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            m_exp = (q.size() > 0) && (q[0] == edge_n);
            if (m_exp) void'(q.pop_front());
            n_tests++;
            assert (tick === m_exp) else begin
                n_fail++;
                $error("FAIL tick@edge%0d: observed %b expected %b", edge_n, tick, m_exp);
            end
        end
    end

    function automatic int period(input int r);
        return BASE_DIV << (3 - r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_until(input int limit);
        while (nt <= limit) begin
            q.push_back(nt);
            nt += cur_p;
        end
    endtask

    task automatic step_to(input int e);
        push_until(e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Drive btn high at edge e and expect acceptance 3+L edges later.
    task automatic press(input int e, input int new_rate, input string tag);
        int u;
        step_to(e);
        btn = 1'b1;
        u = e + DEB_CYCLES + L;
        step_to(u - 1);
        check({tag, "_rate_before"}, {30'd0, rate}, (new_rate + 3) % 4);
        check({tag, "_lvl_before"}, {31'd0, btn_level}, 0);
        nt    = u + period(new_rate);
        cur_p = period(new_rate);
        step_to(u);
        check({tag, "_rate"}, {30'd0, rate}, new_rate);
        check({tag, "_lvl"}, {31'd0, btn_level}, 1);
        btn = 1'b0;
        step_to(u + DEB_CYCLES + L + 1);
        check({tag, "_release_lvl"}, {31'd0, btn_level}, 0);
        check({tag, "_release_rate"}, {30'd0, rate}, new_rate);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int u_last;
        int e;
        reset  = 1'b1;
        btn    = 1'b0;
        run_en = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_tick", {31'd0, tick}, 0);
        check("rst_rate", {30'd0, rate}, 0);
        check("rst_lvl", {31'd0, btn_level}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        nt    = period(0);
        cur_p = period(0);

        // Rate 0 cadence after reset release.
        step_to(100);
        check("r0_rate", {30'd0, rate}, 0);

        // Glitch one cycle shorter than the debounce window.
        btn = 1'b1;
        step_to(102);
        btn = 1'b0;
        step_to(110);
        check("glitch_lvl", {31'd0, btn_level}, 0);
        check("glitch_rate", {30'd0, rate}, 0);

        // Four accepted presses: 1, 2, 3, then wrap to 0.
        press(110, 1, "p1");
        step_to(edge_n + 40);
        press(edge_n + 6, 2, "p2");
        step_to(edge_n + 20);
        press(edge_n + 6, 3, "p3");
        u_last = edge_n - (DEB_CYCLES + L + 1);
        step_to(edge_n + 6);
        // Acceptance lands on a rate-3 terminal edge; that tick must vanish.
        press(u_last + 24 - DEB_CYCLES - L, 0, "p4");
        step_to(edge_n + 70);

        // Freeze the prescaler for 10 cycles mid-period.
        e = nt - 15;
        step_to(e);
        run_en = 1'b0;
        nt += 10;
        step_to(e + 10);
        run_en = 1'b1;
        step_to(nt + 2);
        check("freeze_rate", {30'd0, rate}, 0);

        // Reach rate 1, then reset in the middle of a new debounce.
        press(edge_n + 6, 1, "p5");
        e = edge_n + 6;
        step_to(e);
        btn = 1'b1;
        step_to(e + 1);
        check("pre_rst_rate", {30'd0, rate}, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_rate", {30'd0, rate}, 0);
        check("async_rst_lvl", {31'd0, btn_level}, 0);
        check("async_rst_tick", {31'd0, tick}, 0);
        q.delete();
        repeat (3) @(negedge clk);
        check("held_rst_rate", {30'd0, rate}, 0);
        reset = 1'b1;
        nt    = period(0);
        cur_p = period(0);

        // Button held through reset is accepted as a fresh press.
        press(0, 1, "held");
        step_to(edge_n + 40);

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
